// File: rtl/hopn_pipe_meas.sv
// hopn_pipe_meas
//   HOPS-deep register pipeline carrying WIDTH-bit data, a valid bit and a
//   measurement tag per stage. It has a global stall, a synchronous clear per
//   stage and a saturating count of words leaving the output. A small FSM tags
//   one accepted word and reports how many cycles that word took to cross the
//   pipeline.
//
// Ports
//   clock0      : sole clock, rising edge
//   rst1        : asynchronous active-high reset
//   start/din   : input valid and data; accepted when start & !stall & !stage_clr[0]
//   stall       : every stage holds its contents
//   stage_clr   : per-stage synchronous clear (valid, data, tag)
//   measure_req : arm a latency measurement (only honoured while idle)
//   dout        : data of the last stage
//   dout_valid  : valid of the last stage
//   occupancy   : number of valid stages (combinational popcount)
//   xfer_count  : saturating count of departed words
//   lat_value   : last measured latency in cycles
//   lat_done    : one-cycle pulse when lat_value has just been updated
//   lat_err     : one-cycle pulse when the tagged word was cleared in flight
//   meas_busy   : measurement FSM is not idle
module hopn_pipe_meas #(
    parameter int WIDTH = 8,
    parameter int HOPS  = 5,
    parameter int CNT_W = 16
) (
    input  logic                        clock0,
    input  logic                        rst1,
    input  logic                        start,
    input  logic [WIDTH-1:0]            din,
    input  logic                        stall,
    input  logic [HOPS-1:0]             stage_clr,
    input  logic                        measure_req,
    output logic [WIDTH-1:0]            dout,
    output logic                        dout_valid,
    output logic [$clog2(HOPS+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]            xfer_count,
    output logic [CNT_W-1:0]            lat_value,
    output logic                        lat_done,
    output logic                        lat_err,
    output logic                        meas_busy
);

    localparam int OCC_W = $clog2(HOPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COUNT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [HOPS-1:0]  valid_q, valid_d;
    logic [HOPS-1:0]  tag_q, tag_d;
    logic [WIDTH-1:0] data_q [HOPS];
    logic [WIDTH-1:0] data_d [HOPS];
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;

    logic accept;
    logic depart;
    logic tag_in;

    assign accept = start & ~stall & ~stage_clr[0];
    assign depart = valid_q[HOPS-1] & ~stall & ~stage_clr[HOPS-1];
    assign tag_in = (state_q == S_ARMED) & accept;

    // Stage update. Each stage reads the pre-edge contents of its predecessor,
    // so a clear on stage i-1 does not stop its old word moving into stage i.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;

        if (stage_clr[0]) begin
            valid_d[0] = 1'b0;
            tag_d[0]   = 1'b0;
            data_d[0]  = '0;
        end else if (!stall) begin
            valid_d[0] = start;
            tag_d[0]   = tag_in;
            data_d[0]  = din;
        end

        for (int i = 1; i < HOPS; i++) begin
            if (stage_clr[i]) begin
                valid_d[i] = 1'b0;
                tag_d[i]   = 1'b0;
                data_d[i]  = '0;
            end else if (!stall) begin
                valid_d[i] = valid_q[i-1];
                tag_d[i]   = tag_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end

        // An aborted measurement must leave no tag behind.
        if (state_q == S_ABORT) begin
            tag_d = '0;
        end
    end

    always_comb begin
        xfer_d = xfer_q;
        if (depart && (xfer_q != CNT_MAX)) begin
            xfer_d = xfer_q + CNT_ONE;
        end
    end

    // Measurement FSM. The counter starts at 1 on the tagging edge and keeps
    // running through stalls, so the value held on the departure edge is the
    // full entry-to-exit cycle count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (measure_req) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (accept) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                if (|(tag_q & stage_clr)) begin
                    state_d = S_ABORT;
                end else if (tag_q[HOPS-1] && depart) begin
                    lat_d   = cnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            tag_q   <= '0;
            for (int i = 0; i < HOPS; i++) begin
                data_q[i] <= '0;
            end
            xfer_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            for (int i = 0; i < HOPS; i++) begin
                data_q[i] <= data_d[i];
            end
            xfer_q  <= xfer_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < HOPS; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign dout       = data_q[HOPS-1];
    assign dout_valid = valid_q[HOPS-1];
    assign xfer_count = xfer_q;
    assign lat_value  = lat_q;
    assign lat_done   = (state_q == S_DONE);
    assign lat_err    = (state_q == S_ABORT);
    assign meas_busy  = (state_q != S_IDLE);

endmodule
